// File: rtl/riscv_imm_pkg.sv
// Shared immediate-type codes and stage-1 record for the immediate encoder.
package riscv_imm_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned IMMSRC_W = 3;

   localparam logic [IMMSRC_W-1:0] IMM_I    = 3'b000;
   localparam logic [IMMSRC_W-1:0] IMM_S    = 3'b001;
   localparam logic [IMMSRC_W-1:0] IMM_B    = 3'b010;
   localparam logic [IMMSRC_W-1:0] IMM_J    = 3'b011;
   localparam logic [IMMSRC_W-1:0] IMM_U    = 3'b100;
   localparam logic [IMMSRC_W-1:0] IMM_UIMM = 3'b101;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic            err;
   } s1_rec_t;

   // True when v[XLEN-1:lsb] are all equal, i.e. v fits a signed field whose sign bit is lsb.
   function automatic logic sign_run_ok(input logic [XLEN-1:0] v, input int unsigned lsb);
      logic signed [XLEN-1:0] t;
      t = $signed(v) >>> lsb;
      return (t == '0) || (t == '1);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters an immediate into an instruction word by type and flags unrepresentable values.
module imm_pack
   import riscv_imm_pkg::*;
(
   input  logic [XLEN-1:0]     base,
   input  logic [IMMSRC_W-1:0] immsrc,
   input  logic [XLEN-1:0]     imm,
   output logic [XLEN-1:0]     instr,
   output logic                err
);

   logic [XLEN-1:0] enc;
   logic            legal;

   always_comb begin
      enc   = base;
      legal = 1'b0;
      case (immsrc)
         IMM_I: begin
            enc[31:20] = imm[11:0];
            legal      = sign_run_ok(imm, 11);
         end
         IMM_S: begin
            enc[31:25] = imm[11:5];
            enc[11:7]  = imm[4:0];
            legal      = sign_run_ok(imm, 11);
         end
         IMM_B: begin
            enc[31]    = imm[12];
            enc[7]     = imm[11];
            enc[30:25] = imm[10:5];
            enc[11:8]  = imm[4:1];
            legal      = !imm[0] && sign_run_ok(imm, 12);
         end
         IMM_J: begin
            enc[31]    = imm[20];
            enc[19:12] = imm[19:12];
            enc[20]    = imm[11];
            enc[30:21] = imm[10:1];
            legal      = !imm[0] && sign_run_ok(imm, 20);
         end
         IMM_U: begin
            enc[31:12] = imm[31:12];
            legal      = (imm[11:0] == 12'h000);
         end
         IMM_UIMM: begin
            enc[24:20] = imm[4:0];
            legal      = (imm[31:5] == 27'h0);
         end
         default: legal = 1'b0;
      endcase
      // Error beats pass the base word through untouched.
      instr = legal ? enc : base;
      err   = !legal;
   end

endmodule

// File: rtl/instr_imm_encoder.sv
// Two-stage valid/ready immediate encoder feeding the instruction-memory write port,
// with a word-aligned address counter and a saturating error counter.
module instr_imm_encoder
   import riscv_imm_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int unsigned       ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_immsrc,
   input  logic [31:0]          in_base,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [ADDR_W-1:0]    out_addr,
   output logic                 out_err,
   input  logic                 addr_load,
   input  logic [ADDR_W-1:0]    addr_load_val,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   logic            s1_valid;
   s1_rec_t         s1_rec;
   logic [XLEN-1:0] pack_instr;
   logic            pack_err;
   logic            s2_free;
   logic            in_hs;
   logic            s1_adv;
   logic            out_hs;
   logic [ADDR_W-1:0] addr_q;

   imm_pack u_imm_pack (
      .base   (in_base),
      .immsrc (in_immsrc),
      .imm    (in_imm),
      .instr  (pack_instr),
      .err    (pack_err)
   );

   assign s2_free  = !out_valid || out_ready;
   // Held low during reset so nothing is accepted into a pipeline being flushed.
   assign in_ready = reset_n && (!s1_valid || s2_free);
   assign in_hs    = in_valid && in_ready;
   assign s1_adv   = s1_valid && s2_free;
   assign out_hs   = out_valid && out_ready;
   assign out_addr = addr_q;

   // Stage 1: encode result and legality.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_rec   <= '0;
      end else if (in_hs) begin
         s1_valid <= 1'b1;
         s1_rec   <= '{instr: pack_instr, err: pack_err};
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
      end else if (s1_adv) begin
         out_valid <= 1'b1;
         out_instr <= s1_rec.instr;
         out_err   <= s1_rec.err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Load wins over increment; a beat leaving in the load cycle already carries the old value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= RESET_ADDR;
      end else if (addr_load) begin
         addr_q <= {addr_load_val[ADDR_W-1:2], 2'b00};
      end else if (out_hs && !out_err) begin
         addr_q <= addr_q + ADDR_STEP;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (out_hs && out_err && !(&err_count)) begin
         err_count <= err_count + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Directed and randomized checks of instr_imm_encoder against a decode-based reference model.
module tb_instr_imm_encoder;
   import riscv_imm_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_err, addr_load;
   logic [2:0]  in_immsrc;
   logic [31:0] in_base, in_imm, out_instr, out_addr, addr_load_val;
   logic [7:0]  err_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] base;
      logic [31:0] imm;
      logic [2:0]  src;
   } beat_t;
   beat_t sb[$];

   logic [31:0] exp_addr;
   int          exp_errc;
   logic        stalled_prev, ld_prev, held_err;
   logic [31:0] held_instr, held_addr;
   logic        acc;

   always #5 clk = ~clk;

   instr_imm_encoder dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_immsrc     (in_immsrc),
      .in_base       (in_base),
      .in_imm        (in_imm),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_addr      (out_addr),
      .out_err       (out_err),
      .addr_load     (addr_load),
      .addr_load_val (addr_load_val),
      .err_count     (err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Representable ranges stated as plain integer bounds.
   function automatic logic ref_legal(input logic [2:0] src, input logic [31:0] imm);
      longint s;
      s = longint'($signed(imm));
      case (src)
         3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
         3'd2:       return (s % 2 == 0) && (s >= -4096) && (s <= 4095);
         3'd3:       return (s % 2 == 0) && (s >= -1048576) && (s <= 1048575);
         3'd4:       return (imm % 4096) == 0;
         3'd5:       return imm < 32;
         default:    return 1'b0;
      endcase
   endfunction

   // Decode-side immediate generator.
   function automatic logic [31:0] ref_decode(input logic [31:0] i, input logic [2:0] src);
      case (src)
         3'd0:    return {{20{i[31]}}, i[31:20]};
         3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'd4:    return {i[31:12], 12'h000};
         default: return {27'h0, i[24:20]};
      endcase
   endfunction

   function automatic logic [31:0] ref_mask(input logic [2:0] src);
      case (src)
         3'd0:       return 32'hFFF0_0000;
         3'd1, 3'd2: return 32'hFE00_0F80;
         3'd3, 3'd4: return 32'hFFFF_F000;
         3'd5:       return 32'h01F0_0000;
         default:    return 32'h0;
      endcase
   endfunction

   // One clock cycle: drive, evaluate handshakes against the model, advance past the edge.
   task automatic tick(input logic v, input logic [2:0] src, input logic [31:0] base,
                       input logic [31:0] imm, input logic ordy, input logic ld,
                       input logic [31:0] ldv, output logic accepted);
      beat_t b;
      logic  ohs, berr;
      in_valid = v; in_immsrc = src; in_base = base; in_imm = imm;
      out_ready = ordy; addr_load = ld; addr_load_val = ldv;
      #1;
      if (stalled_prev) begin
         chk("stall_instr", out_instr, held_instr);
         chk("stall_err", 32'(out_err), 32'(held_err));
         if (!ld_prev) chk("stall_addr", out_addr, held_addr);
      end
      ohs  = out_valid && out_ready;
      berr = 1'b0;
      accepted = v && in_ready;
      if (ohs) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 32'(sb.size()), 32'd1);
         end else begin
            b    = sb.pop_front();
            berr = !ref_legal(b.src, b.imm);
            chk("beat_err", 32'(out_err), 32'(berr));
            if (berr) begin
               chk("beat_base", out_instr, b.base);
            end else begin
               chk("beat_decode", ref_decode(out_instr, b.src), b.imm);
               chk("beat_passthru", out_instr & ~ref_mask(b.src), b.base & ~ref_mask(b.src));
            end
            chk("beat_addr", out_addr, exp_addr);
         end
      end
      if (accepted) sb.push_back('{base: base, imm: imm, src: src});
      stalled_prev = out_valid && !out_ready;
      held_instr = out_instr; held_err = out_err; held_addr = out_addr;
      @(posedge clk);
      #1;
      ld_prev = ld;
      if (ld) exp_addr = ldv & 32'hFFFF_FFFC;
      else if (ohs && !berr) exp_addr = exp_addr + 32'd4;
      if (ohs && berr && exp_errc < 255) exp_errc++;
      chk("err_count", 32'(err_count), 32'(exp_errc));
      chk("out_addr", out_addr, exp_addr);
      in_valid = 1'b0;
      addr_load = 1'b0;
   endtask

   task automatic idle(input logic ordy);
      logic a;
      tick(1'b0, 3'd0, 32'h0, 32'h0, ordy, 1'b0, 32'h0, a);
   endtask

   task automatic send(input logic [2:0] src, input logic [31:0] base, input logic [31:0] imm);
      logic a;
      tick(1'b1, src, base, imm, 1'b0, 1'b0, 32'h0, a);
      chk("send_accept", 32'(a), 32'd1);
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (!out_valid && n < 8) begin
         idle(1'b0);
         n++;
      end
      chk(tag, 32'(out_valid), 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_instr"}, out_instr, 32'h0);
      chk({tag, "_out_err"}, 32'(out_err), 32'd0);
      chk({tag, "_out_addr"}, out_addr, 32'h0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      int          nacc, guard, sent, cyc;
      logic        pend, ordy;
      logic [2:0]  p_src;
      logic [31:0] p_base, p_imm, r;

      reset_n = 1'b0; in_valid = 1'b0; in_immsrc = 3'd0; in_base = 32'h0; in_imm = 32'h0;
      out_ready = 1'b0; addr_load = 1'b0; addr_load_val = 32'h0;
      stalled_prev = 1'b0; ld_prev = 1'b0; held_err = 1'b0; held_instr = 32'h0; held_addr = 32'h0;
      exp_addr = 32'h0; exp_errc = 0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_state("rst");
      reset_n = 1'b1;
      #1;
      chk("in_ready_release", 32'(in_ready), 32'd1);

      // I-type with latency check
      send(IMM_I, 32'h0000_0013, 32'hFFFF_FFFF);
      chk("i_lat1", 32'(out_valid), 32'd0);
      idle(1'b0);
      chk("i_lat2", 32'(out_valid), 32'd1);
      chk("i_instr", out_instr, 32'hFFF0_0013);
      chk("i_err", 32'(out_err), 32'd0);
      chk("i_addr", out_addr, 32'h0);
      idle(1'b1);

      // B-type odd offset is an error and does not advance the address
      send(IMM_B, 32'h0000_0063, 32'h0000_0801);
      wait_out("b_odd_valid");
      chk("b_odd_instr", out_instr, 32'h0000_0063);
      chk("b_odd_err", 32'(out_err), 32'd1);
      idle(1'b1);
      chk("b_odd_errcnt", 32'(err_count), 32'd1);
      chk("b_odd_addr", out_addr, 32'h4);

      send(IMM_B, 32'h0000_0063, 32'hFFFF_F000);
      wait_out("b_neg_valid");
      chk("b_neg_instr", out_instr, 32'h8000_0063);
      chk("b_neg_err", 32'(out_err), 32'd0);
      idle(1'b1);

      send(IMM_U, 32'h0000_0037, 32'h1234_5000);
      wait_out("u_valid");
      chk("u_instr", out_instr, 32'h1234_5037);
      idle(1'b1);

      send(IMM_UIMM, 32'h0000_1013, 32'd32);
      wait_out("uimm_valid");
      chk("uimm_err", 32'(out_err), 32'd1);
      chk("uimm_instr", out_instr, 32'h0000_1013);
      idle(1'b1);

      send(IMM_J, 32'h0000_006F, 32'h000F_FFFE);
      wait_out("j_valid");
      chk("j_instr", out_instr, 32'h7FFF_F06F);
      chk("j_err", 32'(out_err), 32'd0);
      idle(1'b1);

      send(IMM_J, 32'h0000_006F, 32'h0010_0000);
      wait_out("j_big_valid");
      chk("j_big_err", 32'(out_err), 32'd1);
      idle(1'b1);
      chk("errcnt_3", 32'(err_count), 32'd3);

      // Backpressure: two beats buffer, then in_ready drops
      tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, acc);
      chk("bp_addr_start", out_addr, 32'h0);
      nacc = 0;
      for (int c = 0; c < 3; c++) begin
         tick(1'b1, IMM_I, 32'h0000_0013, 32'(nacc + 1), 1'b0, 1'b0, 32'h0, acc);
         if (acc) nacc++;
      end
      chk("bp_accepted", 32'(nacc), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      guard = 0;
      while (nacc < 5 && guard < 20) begin
         tick(1'b1, IMM_I, 32'h0000_0013, 32'(nacc + 1), 1'b1, 1'b0, 32'h0, acc);
         if (acc) nacc++;
         guard++;
      end
      chk("bp_all_in", 32'(nacc), 32'd5);
      repeat (4) idle(1'b1);
      chk("bp_drained", 32'(sb.size()), 32'd0);
      chk("bp_addr_end", out_addr, 32'd20);

      // addr_load coinciding with an output handshake
      send(IMM_I, 32'h0000_0093, 32'd5);
      wait_out("ld_valid");
      tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_1003, acc);
      chk("ld_addr", out_addr, 32'h0000_1000);
      send(IMM_I, 32'h0000_0093, 32'd6);
      wait_out("ld_next_valid");
      chk("ld_next_addr", out_addr, 32'h0000_1000);
      idle(1'b1);

      // Address wrap
      tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, acc);
      send(IMM_I, 32'h0000_0013, 32'd7);
      wait_out("wrap_valid");
      chk("wrap_addr_pre", out_addr, 32'hFFFF_FFFC);
      idle(1'b1);
      chk("wrap_addr_post", out_addr, 32'h0);

      // Reset with two beats in flight
      send(IMM_S, 32'h0000_0023, 32'd8);
      send(IMM_S, 32'h0000_0023, 32'd9);
      chk("flight_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_state("midrst");
      sb.delete();
      exp_addr = 32'h0; exp_errc = 0; stalled_prev = 1'b0; ld_prev = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("midrst_release", 32'(in_ready), 32'd1);
      chk("midrst_empty", 32'(out_valid), 32'd0);

      // Randomized round trip
      sent = 0; cyc = 0; pend = 1'b0;
      p_src = 3'd0; p_base = 32'h0; p_imm = 32'h0;
      while ((sent < 10000 || sb.size() > 0) && cyc < 60000) begin
         if (!pend && sent < 10000 && $urandom_range(0, 3) != 0) begin
            pend   = 1'b1;
            p_src  = 3'($urandom_range(0, 7));
            p_base = $urandom;
            r      = $urandom;
            case ($urandom_range(0, 4))
               0:       p_imm = r;
               1:       p_imm = {{19{r[12]}}, r[12:0]};
               2:       p_imm = {{11{r[20]}}, r[20:0]};
               3:       p_imm = {r[31:12], 12'h000};
               default: p_imm = {27'h0, r[5:0]} & 32'h3F;
            endcase
         end
         ordy = (sent >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
         tick(pend, p_src, p_base, p_imm, ordy, 1'b0, 32'h0, acc);
         if (acc) begin
            pend = 1'b0;
            sent++;
         end
         cyc++;
      end
      chk("rand_sent", 32'(sent), 32'd10000);
      chk("rand_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
